// File: rtl/mod_i2c_slave_pkg.sv
// Shared types and constants for the I2C write-only register responder.
// Holds the FSM state encoding, fault codes and the default bus address.
package mod_i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_ADDR  = 3'd2,
        ST_BYTE1     = 3'd3,
        ST_ACK1      = 3'd4,
        ST_BYTE2     = 3'd5,
        ST_ACK2      = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic [3:0] FAULT_NONE       = 4'd0;
    localparam logic [3:0] FAULT_READ_REQ   = 4'd2;
    localparam logic [3:0] FAULT_EXTRA_BYTE = 4'd3;
    localparam logic [3:0] FAULT_EARLY_STOP = 4'd4;

    localparam logic [6:0] DEFAULT_ADDR = 7'h1A;

    // States in which SCL rising edges shift a data bit in.
    function automatic logic is_rx_state(input i2c_state_t st);
        case (st)
            ST_ADDR, ST_BYTE1, ST_BYTE2, ST_WAIT_STOP: is_rx_state = 1'b1;
            default:                                   is_rx_state = 1'b0;
        endcase
    endfunction

    // States belonging to a frame that is still being assembled.
    function automatic logic is_frame_state(input i2c_state_t st);
        case (st)
            ST_ADDR, ST_ACK_ADDR, ST_BYTE1, ST_ACK1,
            ST_BYTE2, ST_ACK2:                         is_frame_state = 1'b1;
            default:                                   is_frame_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mod_i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
// All detections are taken on the synchronized copies only.
module mod_i2c_bus_sync (
    input  logic i_i2c_clk,
    input  logic i_nrst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise_s,
    output logic scl_fall_s,
    output logic start_s,
    output logic stop_s
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;

    // Synchronizer chains and one-cycle history for edge detection.
    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    assign sda_s      = sda_sync_r[1];
    assign scl_rise_s = scl_sync_r[1] & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r[1] & scl_prev_r;
    // SDA may only move while SCL is high (both samples) for START/STOP.
    assign start_s    = scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
    assign stop_s     = scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];

endmodule

// File: rtl/mod_i2c_slave.sv
// Write-only I2C responder: address byte, then {reg[6:0], data[8]} and data[7:0].
// A completed two-byte write produces a one-cycle strobe with the captured values.
module mod_i2c_slave
    import mod_i2c_slave_pkg::*;
#(
    parameter logic [6:0] P_ADDR = DEFAULT_ADDR
) (
    input  logic       i_i2c_clk,
    input  logic       i_nrst,
    input  logic       i_i2c_sdclk,
    inout  tri         b_i2c_sdat,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_register,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    output logic [3:0] o_fault_code
);

    i2c_state_t state_r;
    i2c_state_t state_nxt_s;

    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;

    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       byte_done_r;
    logic       skip_ack_r;
    logic       addr_ok_r;
    logic [7:0] byte1_r;
    logic [3:0] fault_r;
    logic [6:0] wr_register_r;
    logic [8:0] wr_data_r;

    logic       ack_drive_r;
    logic       busy_r;
    logic       wr_valid_r;
    logic       ack_drive_nxt_s;
    logic       busy_nxt_s;
    logic       wr_valid_nxt_s;

    logic       match_wr_s;
    logic       read_req_s;

    mod_i2c_bus_sync u_bus_sync (
        .i_i2c_clk  (i_i2c_clk),
        .i_nrst     (i_nrst),
        .scl_in     (i_i2c_sdclk),
        .sda_in     (b_i2c_sdat),
        .sda_s      (sda_s),
        .scl_rise_s (scl_rise_s),
        .scl_fall_s (scl_fall_s),
        .start_s    (start_s),
        .stop_s     (stop_s)
    );

    assign match_wr_s = (shift_r == {P_ADDR, 1'b0});
    assign read_req_s = (shift_r == {P_ADDR, 1'b1});

    // FSM state register.
    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: START/STOP override, otherwise advance on SCL falling edges.
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ST_ADDR;
        end else if (stop_s) begin
            state_nxt_s = ST_IDLE;
        end else if (scl_fall_s) begin
            case (state_r)
                ST_ADDR:      state_nxt_s = byte_done_r ? ST_ACK_ADDR : ST_ADDR;
                ST_ACK_ADDR:  state_nxt_s = addr_ok_r ? ST_BYTE1 : ST_WAIT_STOP;
                ST_BYTE1:     state_nxt_s = byte_done_r ? ST_ACK1 : ST_BYTE1;
                ST_ACK1:      state_nxt_s = ST_BYTE2;
                ST_BYTE2:     state_nxt_s = byte_done_r ? ST_ACK2 : ST_BYTE2;
                ST_ACK2:      state_nxt_s = ST_WAIT_STOP;
                default:      state_nxt_s = state_r;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM outputs, computed from the next state so they register alongside it.
    always_comb begin
        ack_drive_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_ACK_ADDR: begin
                if (state_r == ST_ADDR) begin
                    ack_drive_nxt_s = match_wr_s;
                end else begin
                    ack_drive_nxt_s = addr_ok_r;
                end
            end
            ST_ACK1, ST_ACK2: ack_drive_nxt_s = 1'b1;
            default:          ack_drive_nxt_s = 1'b0;
        endcase
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        wr_valid_nxt_s = (state_r == ST_ACK2) && (state_nxt_s == ST_WAIT_STOP);
    end

    // Registered FSM outputs.
    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ack_drive_r <= 1'b0;
            busy_r      <= 1'b0;
            wr_valid_r  <= 1'b0;
        end else begin
            ack_drive_r <= ack_drive_nxt_s;
            busy_r      <= busy_nxt_s;
            wr_valid_r  <= wr_valid_nxt_s;
        end
    end

    // Shift register, bit counter, frame flags, fault code and write capture.
    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            shift_r       <= 8'h00;
            bit_cnt_r     <= 3'd0;
            byte_done_r   <= 1'b0;
            skip_ack_r    <= 1'b0;
            addr_ok_r     <= 1'b0;
            byte1_r       <= 8'h00;
            fault_r       <= FAULT_NONE;
            wr_register_r <= 7'h00;
            wr_data_r     <= 9'h000;
        end else if (start_s) begin
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            skip_ack_r  <= 1'b0;
            addr_ok_r   <= 1'b0;
            fault_r     <= FAULT_NONE;
        end else if (stop_s) begin
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            skip_ack_r  <= 1'b0;
            if (is_frame_state(state_r) && addr_ok_r) begin
                fault_r <= FAULT_EARLY_STOP;
            end
        end else begin
            if (scl_rise_s && is_rx_state(state_r) && !skip_ack_r) begin
                shift_r   <= {shift_r[6:0], sda_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_done_r <= 1'b1;
                end
            end
            if (scl_fall_s && byte_done_r) begin
                byte_done_r <= 1'b0;
                case (state_r)
                    ST_ADDR: begin
                        addr_ok_r <= match_wr_s;
                        if (read_req_s) begin
                            fault_r <= FAULT_READ_REQ;
                        end
                    end
                    ST_BYTE1: byte1_r <= shift_r;
                    // Extra bytes are counted but their ACK slot is skipped.
                    ST_WAIT_STOP: begin
                        skip_ack_r <= 1'b1;
                        if (addr_ok_r) begin
                            fault_r <= FAULT_EXTRA_BYTE;
                        end
                    end
                    default: byte_done_r <= 1'b0;
                endcase
            end else if (scl_fall_s && skip_ack_r) begin
                skip_ack_r <= 1'b0;
            end
            if (wr_valid_nxt_s) begin
                wr_register_r <= byte1_r[7:1];
                wr_data_r     <= {byte1_r[0], shift_r};
            end
        end
    end

    // Release SDA immediately on reset, independent of the clock.
    assign b_i2c_sdat    = (i_nrst && ack_drive_r) ? 1'b0 : 1'bz;

    assign o_wr_valid    = wr_valid_r;
    assign o_wr_register = wr_register_r;
    assign o_wr_data     = wr_data_r;
    assign o_busy        = busy_r;
    assign o_fault_code  = fault_r;

endmodule

// File: tb/tb_mod_i2c_slave.sv
// Self-checking bench for mod_i2c_slave: table of write frames plus
// hand-written repeated-START and reset-during-ACK sequences.
module tb_mod_i2c_slave;

    logic       clk;
    logic       nrst;
    logic       scl;
    logic       sda_m_low;
    wire        sda_w;
    logic       wr_valid;
    logic [6:0] wr_register;
    logic [8:0] wr_data;
    logic       busy;
    logic [3:0] fault_code;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int dut_low_cnt = 0;

    assign sda_w = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    mod_i2c_slave dut (
        .i_i2c_clk     (clk),
        .i_nrst        (nrst),
        .i_i2c_sdclk   (scl),
        .b_i2c_sdat    (sda_w),
        .o_wr_valid    (wr_valid),
        .o_wr_register (wr_register),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) strobe_cnt++;
        if (!sda_m_low && sda_w === 1'b0) dut_low_cnt++;
    end

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [3:0]  exp_ack;
        int          exp_strobe;
        logic [6:0]  exp_reg;
        logic [8:0]  exp_data;
        logic [3:0]  exp_fault;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b0;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(8);
        sda_m_low = 1'b1;
        wait_clk(8);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(4);
        sda_m_low = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);
        sda_m_low = 1'b0;
        wait_clk(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            wait_clk(4);
            sda_m_low = ~b[i];
            wait_clk(4);
            scl = 1'b1;
            wait_clk(8);
            scl = 1'b0;
        end
    endtask

    task automatic ack_bit(output logic acked);
        wait_clk(4);
        sda_m_low = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        acked = (sda_w === 1'b0);
        wait_clk(4);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b, 8);
        ack_bit(acked);
    endtask

    initial begin
        logic [3:0] got_ack;
        logic       a;
        int         s0;
        int         l0;

        vecs[0] = '{32'h00F00D34, 3, 4'b0111, 1, 7'h06, 9'h1F0, 4'd0};
        vecs[1] = '{32'h00F00D36, 3, 4'b0000, 0, 7'h06, 9'h1F0, 4'd0};
        vecs[2] = '{32'h00000035, 1, 4'b0000, 0, 7'h06, 9'h1F0, 4'd2};
        vecs[3] = '{32'hAA5A1534, 4, 4'b0111, 1, 7'h0A, 9'h15A, 4'd3};
        vecs[4] = '{32'h00000D34, 2, 4'b0011, 0, 7'h0A, 9'h15A, 4'd4};
        vecs[5] = '{32'h00F00DB4, 3, 4'b0000, 0, 7'h0A, 9'h15A, 4'd0};

        nrst      = 1'b0;
        scl       = 1'b1;
        sda_m_low = 1'b0;
        wait_clk(5);
        check("rst_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_reg", {25'd0, wr_register}, 32'd0);
        check("rst_data", {23'd0, wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fault", {28'd0, fault_code}, 32'd0);
        check("rst_sda", {31'd0, sda_w}, 32'd1);
        nrst = 1'b1;
        wait_clk(10);

        for (int v = 0; v < 6; v++) begin
            s0 = strobe_cnt;
            l0 = dut_low_cnt;
            got_ack = 4'b0000;
            i2c_start();
            check($sformatf("v%0d_busy_mid", v), {31'd0, busy}, 32'd1);
            for (int k = 0; k < vecs[v].n; k++) begin
                send_byte(vecs[v].bytes[8*k +: 8], a);
                got_ack[k] = a;
            end
            i2c_stop();
            check($sformatf("v%0d_acks", v), {28'd0, got_ack}, {28'd0, vecs[v].exp_ack});
            check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_strobe);
            check($sformatf("v%0d_sda_low", v), {31'd0, (dut_low_cnt != l0)},
                  {31'd0, (vecs[v].exp_ack != 4'd0)});
            check($sformatf("v%0d_reg", v), {25'd0, wr_register}, {25'd0, vecs[v].exp_reg});
            check($sformatf("v%0d_data", v), {23'd0, wr_data}, {23'd0, vecs[v].exp_data});
            check($sformatf("v%0d_fault", v), {28'd0, fault_code}, {28'd0, vecs[v].exp_fault});
            check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
            wait_clk(10);
        end

        // Repeated START in the middle of BYTE2, then a full frame.
        s0 = strobe_cnt;
        got_ack = 4'b0000;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h0D, a);
        send_bits(8'hF0, 4);
        check("rs_busy_partial", {31'd0, busy}, 32'd1);
        check("rs_no_strobe_partial", strobe_cnt - s0, 0);
        i2c_start();
        send_byte(8'h34, a); got_ack[0] = a;
        send_byte(8'h1E, a); got_ack[1] = a;
        send_byte(8'h00, a); got_ack[2] = a;
        i2c_stop();
        check("rs_acks", {28'd0, got_ack}, 32'd7);
        check("rs_strobes", strobe_cnt - s0, 1);
        check("rs_reg", {25'd0, wr_register}, 32'h0F);
        check("rs_data", {23'd0, wr_data}, 32'h000);
        check("rs_fault", {28'd0, fault_code}, 32'd0);
        wait_clk(10);

        // Reset asserted while ACK1 holds SDA low.
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'h34, a);
        send_bits(8'h0D, 8);
        sda_m_low = 1'b0;
        wait_clk(6);
        check("ack1_driving", {31'd0, sda_w}, 32'd0);
        nrst = 1'b0;
        #1;
        check("rst_mid_sda", {31'd0, sda_w}, 32'd1);
        check("rst_mid_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_mid_reg", {25'd0, wr_register}, 32'd0);
        check("rst_mid_data", {23'd0, wr_data}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_fault", {28'd0, fault_code}, 32'd0);
        wait_clk(3);
        nrst = 1'b1;
        ack_bit(a);
        check("rst_ack_released", {31'd0, a}, 32'd0);
        i2c_stop();
        check("rst_no_strobe", strobe_cnt - s0, 0);
        wait_clk(10);
        got_ack = 4'b0000;
        i2c_start();
        send_byte(8'h34, a); got_ack[0] = a;
        send_byte(8'h0D, a); got_ack[1] = a;
        send_byte(8'hF0, a); got_ack[2] = a;
        i2c_stop();
        check("post_rst_acks", {28'd0, got_ack}, 32'd7);
        check("post_rst_strobes", strobe_cnt - s0, 1);
        check("post_rst_reg", {25'd0, wr_register}, 32'h06);
        check("post_rst_data", {23'd0, wr_data}, 32'h1F0);
        check("post_rst_fault", {28'd0, fault_code}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
